rift_test_monitor: RTL and testbench

Synthesizable, parametrised completion monitor for riscv-tests style programs running on one or more RiftCore harts. Watches per-hart commit-stage ECALL events with the hart's architectural x3 (gp), plus a memory-write channel for `tohost` stores. Resolves a sticky PASS / FAIL / TIMEOUT verdict with failing test number and hart index. Sits beside `riftChip`, so simulation benches and FPGA builds share one pass/fail mechanism instead of bench-only probes.

---
 rtl/rift_test_monitor_if.sv | 32 +++
 rtl/rift_test_monitor.sv | 85 ++++++++
 tb/tb_rift_test_monitor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rift_test_monitor_if.sv
// rift_test_monitor_if: event inputs and verdict outputs of the riscv-tests completion monitor
interface rift_test_monitor_if #(
  parameter int NHART = 1,
  parameter int DW = 64,
  parameter int AW = 64,
  parameter int TW = 32
);
  logic start;
  logic [TW-1:0] timeout_limit;
  logic [NHART-1:0] ecall_vld;
  logic [NHART*DW-1:0] gp_val;
  logic wr_vld;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic busy;
  logic done;
  logic pass;
  logic fail;
  logic timeout;
  logic [DW-2:0] fail_code;
  logic [2:0] fail_hart;
  logic [NHART-1:0] hart_passed;
  logic [TW-1:0] cycle_cnt;
  modport master (
    output start, timeout_limit, ecall_vld, gp_val, wr_vld, wr_addr, wr_data,
    input busy, done, pass, fail, timeout, fail_code, fail_hart, hart_passed, cycle_cnt
  );
  modport slave (
    input start, timeout_limit, ecall_vld, gp_val, wr_vld, wr_addr, wr_data,
    output busy, done, pass, fail, timeout, fail_code, fail_hart, hart_passed, cycle_cnt
  );
endinterface

// File: rtl/rift_test_monitor.sv
// rift_test_monitor: sticky PASS/FAIL/TIMEOUT verdict from per-hart ECALL gp values and tohost stores
module rift_test_monitor #(
  parameter int NHART = 1,
  parameter int DW = 64,
  parameter int AW = 64,
  parameter int TW = 32,
  parameter logic [63:0] TOHOST_ADDR = 64'h8000_1000
) (
  input logic CLK,
  input logic RSTn,
  rift_test_monitor_if.slave m
);
  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} st_t;
  st_t st, nxt;
  logic [TW-1:0] lim;
  logic [NHART-1:0] pm;
  logic [DW-2:0] ecode;
  logic [2:0] ehart;
  logic [DW-1:0] g;
  logic ef, th, tf;
  always_comb begin
    ef = 1'b0;
    ecode = '0;
    ehart = '0;
    g = '0;
    pm = m.hart_passed;
    th = m.wr_vld && m.wr_addr == AW'(TOHOST_ADDR) && m.wr_data[0];
    tf = th && m.wr_data != DW'(1);
    // descending scan so the lowest failing hart is the one left standing
    for (int h = NHART - 1; h >= 0; h--) begin
      g = m.gp_val[h*DW +: DW];
      if (m.ecall_vld[h] && g == DW'(1)) pm[h] = 1'b1;
      if (m.ecall_vld[h] && g != DW'(1)) begin
        ef = 1'b1;
        ecode = g[DW-1:1];
        ehart = 3'(h);
      end
    end
    if (th && !tf) pm = '1;
    nxt = st;
    if (m.start) nxt = RUN;
    else if (st == RUN)
      nxt = (ef || tf) ? FAIL : (&pm) ? PASS :
            (lim != '0 && m.cycle_cnt + TW'(1) == lim) ? TIMEOUT : RUN;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st <= IDLE;
      lim <= '0;
      m.busy <= 1'b0;
      m.done <= 1'b0;
      m.pass <= 1'b0;
      m.fail <= 1'b0;
      m.timeout <= 1'b0;
      m.fail_code <= '0;
      m.fail_hart <= '0;
      m.hart_passed <= '0;
      m.cycle_cnt <= '0;
    end else begin
      st <= nxt;
      m.busy <= nxt == RUN;
      m.done <= nxt inside {PASS, FAIL, TIMEOUT};
      m.pass <= nxt == PASS;
      m.fail <= nxt == FAIL;
      m.timeout <= nxt == TIMEOUT;
      if (m.start) begin
        lim <= m.timeout_limit;
        m.cycle_cnt <= '0;
        m.hart_passed <= '0;
        m.fail_code <= '0;
        m.fail_hart <= '0;
      end else if (st == RUN) begin
        m.cycle_cnt <= (&m.cycle_cnt) ? m.cycle_cnt : m.cycle_cnt + TW'(1);
        m.hart_passed <= pm;
        if (ef) begin
          m.fail_code <= ecode;
          m.fail_hart <= ehart;
        end else if (tf) begin
          m.fail_code <= m.wr_data[DW-1:1];
          m.fail_hart <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rift_test_monitor.sv
// tb_rift_test_monitor: directed checks of a single-hart and a four-hart monitor
module tb_rift_test_monitor;
  localparam logic [63:0] TH = 64'h8000_1000;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  int npass = 0;
  int ntot = 0;
  rift_test_monitor_if #(.NHART(1)) a();
  rift_test_monitor_if #(.NHART(4)) b();
  rift_test_monitor #(.NHART(1)) u_a (.CLK(CLK), .RSTn(RSTn), .m(a));
  rift_test_monitor #(.NHART(4)) u_b (.CLK(CLK), .RSTn(RSTn), .m(b));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic st_a(input logic [31:0] l);
    a.timeout_limit = l;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
  endtask
  task automatic st_b();
    b.timeout_limit = 0;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
  endtask
  task automatic ec_a(input logic [63:0] gp);
    a.ecall_vld = 1'b1;
    a.gp_val = gp;
    tick();
    a.ecall_vld = 1'b0;
  endtask
  task automatic wr_a(input logic [63:0] ad, input logic [63:0] d);
    a.wr_vld = 1'b1;
    a.wr_addr = ad;
    a.wr_data = d;
    tick();
    a.wr_vld = 1'b0;
  endtask
  initial begin
    a.start = 0; a.timeout_limit = 0; a.ecall_vld = 0; a.gp_val = 0;
    a.wr_vld = 0; a.wr_addr = 0; a.wr_data = 0;
    b.start = 0; b.timeout_limit = 0; b.ecall_vld = 0; b.gp_val = 0;
    b.wr_vld = 0; b.wr_addr = 0; b.wr_data = 0;
    repeat (2) tick();
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_code", a.fail_code, 0);
    chk("rst_cnt", a.cycle_cnt, 0);
    chk("rst_mask_b", b.hart_passed, 0);
    RSTn = 1'b1;
    tick();
    a.ecall_vld = 1'b1; a.gp_val = 64'h7;
    tick();
    a.ecall_vld = 1'b0;
    chk("idle_ignores", a.done, 0);
    st_a(0);
    chk("start_busy", a.busy, 1);
    chk("start_cnt0", a.cycle_cnt, 0);
    repeat (49) tick();
    chk("cnt49", a.cycle_cnt, 49);
    ec_a(64'h1);
    chk("p1_pass", a.pass, 1);
    chk("p1_done", a.done, 1);
    chk("p1_fail", a.fail, 0);
    chk("p1_busy", a.busy, 0);
    chk("p1_cnt", a.cycle_cnt, 50);
    repeat (5) tick();
    chk("p1_frozen", a.cycle_cnt, 50);
    st_a(0);
    chk("rearm_pass_clr", a.pass, 0);
    ec_a(64'h7);
    chk("f7_fail", a.fail, 1);
    chk("f7_code", a.fail_code, 3);
    chk("f7_hart", a.fail_hart, 0);
    chk("f7_pass", a.pass, 0);
    ec_a(64'h1);
    chk("fail_sticky", a.fail, 1);
    st_a(0);
    chk("rearm_fail_clr", a.fail, 0);
    chk("rearm_code_clr", a.fail_code, 0);
    chk("rearm_busy", a.busy, 1);
    ec_a(64'h0);
    chk("f0_fail", a.fail, 1);
    chk("f0_code", a.fail_code, 0);
    st_a(0);
    ec_a(64'h1);
    chk("rerun_pass", a.pass, 1);
    st_a(0);
    wr_a(TH + 8, 64'h15);
    wr_a(TH, 64'h2);
    chk("th_ign_busy", a.busy, 1);
    chk("th_ign_done", a.done, 0);
    wr_a(TH, 64'h15);
    chk("th_fail", a.fail, 1);
    chk("th_code", a.fail_code, 10);
    chk("th_hart", a.fail_hart, 0);
    st_a(0);
    wr_a(TH, 64'h1);
    chk("th_pass", a.pass, 1);
    chk("th_mask", a.hart_passed, 1);
    st_a(100);
    repeat (98) tick();
    chk("to_pre_busy", a.busy, 1);
    chk("to_pre_cnt", a.cycle_cnt, 98);
    tick();
    chk("to_last_busy", a.busy, 1);
    tick();
    chk("to_timeout", a.timeout, 1);
    chk("to_done", a.done, 1);
    chk("to_cnt", a.cycle_cnt, 100);
    tick();
    chk("to_frozen", a.cycle_cnt, 100);
    st_a(100);
    repeat (99) tick();
    ec_a(64'h1);
    chk("to_late_pass", a.pass, 1);
    chk("to_late_to", a.timeout, 0);
    chk("to_late_cnt", a.cycle_cnt, 100);
    st_a(0);
    repeat (10000) tick();
    chk("nolim_busy", a.busy, 1);
    chk("nolim_to", a.timeout, 0);
    chk("nolim_cnt", a.cycle_cnt, 10000);
    RSTn = 1'b0;
    #1;
    chk("arst_busy", a.busy, 0);
    chk("arst_cnt", a.cycle_cnt, 0);
    tick();
    RSTn = 1'b1;
    tick();
    st_b();
    b.ecall_vld = 4'b1011;
    b.gp_val = {4{64'h1}};
    tick();
    b.ecall_vld = 0;
    repeat (3) tick();
    chk("b_partial_busy", b.busy, 1);
    chk("b_partial_mask", b.hart_passed, 4'b1011);
    b.ecall_vld = 4'b1011;
    tick();
    b.ecall_vld = 0;
    chk("b_repeat_busy", b.busy, 1);
    b.ecall_vld = 4'b0100;
    tick();
    b.ecall_vld = 0;
    chk("b_all_pass", b.pass, 1);
    chk("b_all_mask", b.hart_passed, 4'b1111);
    st_b();
    b.ecall_vld = 4'b1010;
    b.gp_val = {64'h9, 64'h1, 64'h5, 64'h1};
    tick();
    b.ecall_vld = 0;
    chk("b_lo_fail", b.fail, 1);
    chk("b_lo_hart", b.fail_hart, 1);
    chk("b_lo_code", b.fail_code, 2);
    st_b();
    b.ecall_vld = 4'b0101;
    b.gp_val = {64'h1, 64'h3, 64'h1, 64'h1};
    b.wr_vld = 1'b1; b.wr_addr = TH; b.wr_data = 64'h15;
    tick();
    b.ecall_vld = 0; b.wr_vld = 0;
    chk("b_ec_over_th_hart", b.fail_hart, 2);
    chk("b_ec_over_th_code", b.fail_code, 1);
    st_b();
    b.ecall_vld = 4'b0001;
    b.gp_val = {4{64'h1}};
    b.wr_vld = 1'b1; b.wr_addr = TH; b.wr_data = 64'h7;
    tick();
    b.ecall_vld = 0; b.wr_vld = 0;
    chk("b_thfail_over_pass", b.fail, 1);
    chk("b_thfail_code", b.fail_code, 3);
    chk("b_thfail_hart", b.fail_hart, 0);
    b.start = 1'b1;
    b.ecall_vld = 4'b1111;
    tick();
    b.start = 0; b.ecall_vld = 0;
    chk("b_start_drops", b.busy, 1);
    chk("b_start_mask", b.hart_passed, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
